mini_alu_gen: RTL and testbench
===============================

MINI_ALU_GEN -- requirements
Module: mini_alu_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning register and ALU data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, meaning width of each operand/destination field; register file holds 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter IP_WIDTH, default 16, meaning instruction pointer width.
REQ-004 SHALL have parameter LED_WIDTH, default 8, meaning LED output width (<= DATA_WIDTH).
REQ-005 SHALL have parameter STACK_DEPTH, default 4, meaning return-stack entries (>= 1).
REQ-006 SHALL have parameter SIGNED_CMP, default 0, meaning BLE compares signed when 1 and unsigned when 0.
REQ-007 SHALL have port Clock, input, 1, the single clock; all state changes on its rising edge.
REQ-008 SHALL have port Reset_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port iRun, input, 1; when low the whole pipeline holds state.
REQ-010 SHALL have port oIP, output, IP_WIDTH, the fetch address to the instruction ROM.
REQ-011 SHALL have port iInstruction, input, 4+3*ADDR_WIDTH, combinational ROM data for oIP, laid out as {op[3:0], dst, src1, src0}.
REQ-012 SHALL have port oLed, output, LED_WIDTH, the registered LED value.
REQ-013 SHALL have port oFlags, output, 2, the registered flags {C, Z}.
REQ-014 SHALL have port oHalted, output, 1, high while the core is halted.
REQ-015 SHALL have port oError, output, 1, sticky stack fault indication.

Function
REQ-016 SHALL use a two-stage pipeline: fetch latches iInstruction, a valid bit and its address into IR; execute decodes IR, reads the register file combinationally and writes on the next edge.
REQ-017 SHALL advance only on edges with iRun=1 and oHalted=0; otherwise IP, IR, registers, flags, stack and oLed SHALL hold.
REQ-018 SHALL increment IP by 1 per advancing cycle, wrapping from 2**IP_WIDTH-1 to 0.
REQ-019 SHALL decode the opcodes NOP=0, ADD=1, SUB=2, MUL=3, STO=4, BLE=5, JMP=6, LED=7, CALL=8, RET=9, HALT=10; codes 11-15 SHALL execute as NOP.
REQ-020 SHALL compute ADD as R[dst]=R[src1]+R[src0], with C set to the carry out of DATA_WIDTH and Z set when the result is 0.
REQ-021 SHALL compute SUB as R[dst]=R[src1]-R[src0], with C set to the borrow (1 when src1 < src0 unsigned) and Z set when the result is 0.
REQ-022 SHALL compute MUL as the low DATA_WIDTH bits of R[src1]*R[src0], update Z, and leave C at 0.
REQ-023 SHALL execute STO as R[dst] = {src1,src0} zero-extended or truncated to DATA_WIDTH, with flags unchanged.
REQ-024 SHALL take BLE when R[src1] <= R[src0], using signed or unsigned comparison per SIGNED_CMP, and SHALL take JMP unconditionally; the target in both cases is dst zero-extended to IP_WIDTH.
REQ-025 SHALL, on a taken branch, CALL or RET, load IP with the target and clear the IR valid bit, giving exactly one bubble; the flushed instruction SHALL have no effect.
REQ-026 SHALL execute CALL by pushing the IR address + 1 onto the stack and jumping to dst.
REQ-027 SHALL execute RET by popping the stack into IP.
REQ-028 SHALL treat CALL with a full stack or RET with an empty stack as a fault: oError=1, oHalted=1, stack unchanged, no jump.
REQ-029 SHALL execute LED as oLed = R[src1][LED_WIDTH-1:0], taking effect on the next edge.
REQ-030 SHALL execute HALT by setting oHalted=1; once halted, only reset clears oHalted and oError.
REQ-031 SHALL perform no register write or flag change for NOP, BLE, JMP, LED, CALL, RET, HALT or an invalid IR.
REQ-032 SHALL give an instruction in execute the result of the immediately preceding instruction, because writes complete before the next execute read; no forwarding or stall is required.

Reset
REQ-033 SHALL, while Reset_n=0, asynchronously force IP=0, IR valid=0, oLed=0, oFlags=0, stack pointer=0, oHalted=0 and oError=0.
REQ-034 SHALL NOT reset register file contents; software initialises them with STO.
REQ-035 SHALL, when reset is released, fetch address 0 on the first advancing edge; any instruction mid-execute at reset assertion is discarded.

Verification
REQ-036 Bench SHALL run STO R1,3; STO R2,5; ADD R3=R2+R1; LED R3 -> oLed=8 two edges after LED is fetched, Z=0, C=0.
REQ-037 Bench SHALL run, with DATA_WIDTH=16, STO R1,0xFFFF; STO R2,1; ADD R3=R1+R2 -> R3=0, C=1, Z=1; then SUB R4=R2-R1 -> R4=2, C=1.
REQ-038 Bench SHALL run a countdown loop (BLE back to address 2 over 5 iterations) -> oLed sequence 5,4,3,2,1 and one bubble per taken branch.
REQ-039 Bench SHALL run nested CALL five times with STACK_DEPTH=4 -> oError=1 and oHalted=1 after the 5th CALL, IP frozen; RET at top level with an empty stack -> same fault.
REQ-040 Bench SHALL toggle iRun low for 3 cycles mid-program -> all state frozen, and final oLed identical to an uninterrupted run.
REQ-041 Bench SHALL assert Reset_n=0 asynchronously between clock edges mid-loop -> all outputs 0 immediately and execution restarts from IP=0 on release.

Source files
------------

// File: rtl/mini_alu_gen.sv
// Two-stage (fetch/execute) register machine with a small return stack and LED output.
// Taken branches, CALL and RET redirect fetch and squash the single instruction behind them.
module mini_alu_gen #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 8,
    parameter int IP_WIDTH    = 16,
    parameter int LED_WIDTH   = 8,
    parameter int STACK_DEPTH = 4,
    parameter bit SIGNED_CMP  = 1'b0
) (
    input  logic                      Clock,
    input  logic                      Reset_n,
    input  logic                      iRun,
    output logic [IP_WIDTH-1:0]       oIP,
    input  logic [4+3*ADDR_WIDTH-1:0] iInstruction,
    output logic [LED_WIDTH-1:0]      oLed,
    output logic [1:0]                oFlags,
    output logic                      oHalted,
    output logic                      oError
);
    localparam int INSTR_W = 4 + 3 * ADDR_WIDTH;
    localparam int IMM_W   = 2 * ADDR_WIDTH;
    localparam int IMM_EXT = (IMM_W > DATA_WIDTH) ? IMM_W : DATA_WIDTH;
    localparam int TGT_EXT = (ADDR_WIDTH > IP_WIDTH) ? ADDR_WIDTH : IP_WIDTH;
    localparam int SP_W    = $clog2(STACK_DEPTH + 1);

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_MUL  = 4'd3,
        OP_STO  = 4'd4,
        OP_BLE  = 4'd5,
        OP_JMP  = 4'd6,
        OP_LED  = 4'd7,
        OP_CALL = 4'd8,
        OP_RET  = 4'd9,
        OP_HALT = 4'd10
    } opcode_t;

    logic [IP_WIDTH-1:0]   ip;
    logic [INSTR_W-1:0]    ir_instr;
    logic                  ir_valid;
    logic [IP_WIDTH-1:0]   ir_addr;
    logic [DATA_WIDTH-1:0] regs [2**ADDR_WIDTH];
    logic [IP_WIDTH-1:0]   stack [2**SP_W];
    logic [SP_W-1:0]       sp;
    logic [SP_W-1:0]       sp_top;
    logic [LED_WIDTH-1:0]  led;
    logic [1:0]            flags;
    logic                  halted;
    logic                  error;

    opcode_t               op;
    logic [ADDR_WIDTH-1:0] dst;
    logic [ADDR_WIDTH-1:0] src1;
    logic [ADDR_WIDTH-1:0] src0;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH:0]   diff;
    logic [DATA_WIDTH-1:0] prod;
    logic [IMM_EXT-1:0]    imm_ext;
    logic [TGT_EXT-1:0]    tgt_ext;
    logic                  ble_le;
    logic                  stack_full;
    logic                  stack_empty;
    logic                  advance;

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  flags_we;
    logic [1:0]            flags_next;
    logic                  led_we;
    logic                  redirect;
    logic [IP_WIDTH-1:0]   next_ip;
    logic                  push;
    logic                  pop;
    logic                  halt_req;
    logic                  fault;

    assign op   = opcode_t'(ir_instr[INSTR_W-1 -: 4]);
    assign dst  = ir_instr[3*ADDR_WIDTH-1 -: ADDR_WIDTH];
    assign src1 = ir_instr[2*ADDR_WIDTH-1 -: ADDR_WIDTH];
    assign src0 = ir_instr[ADDR_WIDTH-1:0];

    assign a       = regs[src1];
    assign b       = regs[src0];
    assign sum     = {1'b0, a} + {1'b0, b};
    assign diff    = {1'b0, a} - {1'b0, b};
    assign prod    = a * b;
    assign imm_ext = IMM_EXT'({src1, src0});
    assign tgt_ext = TGT_EXT'(dst);
    assign ble_le  = SIGNED_CMP ? ($signed(a) <= $signed(b)) : (a <= b);

    assign stack_full  = (sp == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp == '0);
    assign sp_top      = sp - 1'b1;
    assign advance     = iRun & ~halted;

    // Execute stage: everything the instruction in IR will do on the next advancing edge.
    always_comb begin
        wr_en      = 1'b0;
        wr_data    = '0;
        flags_we   = 1'b0;
        flags_next = flags;
        led_we     = 1'b0;
        redirect   = 1'b0;
        next_ip    = tgt_ext[IP_WIDTH-1:0];
        push       = 1'b0;
        pop        = 1'b0;
        halt_req   = 1'b0;
        fault      = 1'b0;
        if (ir_valid) begin
            case (op)
                OP_ADD: begin
                    wr_en      = 1'b1;
                    wr_data    = sum[DATA_WIDTH-1:0];
                    flags_we   = 1'b1;
                    flags_next = {sum[DATA_WIDTH], sum[DATA_WIDTH-1:0] == '0};
                end
                OP_SUB: begin
                    wr_en      = 1'b1;
                    wr_data    = diff[DATA_WIDTH-1:0];
                    flags_we   = 1'b1;
                    flags_next = {diff[DATA_WIDTH], diff[DATA_WIDTH-1:0] == '0};
                end
                OP_MUL: begin
                    wr_en      = 1'b1;
                    wr_data    = prod;
                    flags_we   = 1'b1;
                    flags_next = {1'b0, prod == '0};
                end
                OP_STO: begin
                    wr_en   = 1'b1;
                    wr_data = imm_ext[DATA_WIDTH-1:0];
                end
                OP_BLE:  redirect = ble_le;
                OP_JMP:  redirect = 1'b1;
                OP_LED:  led_we   = 1'b1;
                OP_CALL: begin
                    if (stack_full) begin
                        fault = 1'b1;
                    end else begin
                        push     = 1'b1;
                        redirect = 1'b1;
                    end
                end
                OP_RET: begin
                    if (stack_empty) begin
                        fault = 1'b1;
                    end else begin
                        pop      = 1'b1;
                        redirect = 1'b1;
                        next_ip  = stack[sp_top];
                    end
                end
                OP_HALT: halt_req = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            ip       <= '0;
            ir_valid <= 1'b0;
            led      <= '0;
            flags    <= '0;
            sp       <= '0;
            halted   <= 1'b0;
            error    <= 1'b0;
        end else if (advance) begin
            if (redirect) begin
                ip       <= next_ip;
                ir_valid <= 1'b0;
            end else begin
                ip       <= ip + 1'b1;
                ir_valid <= 1'b1;
            end
            if (flags_we) flags <= flags_next;
            if (led_we) led <= a[LED_WIDTH-1:0];
            if (push) begin
                sp <= sp + 1'b1;
            end else if (pop) begin
                sp <= sp_top;
            end
            if (halt_req || fault) halted <= 1'b1;
            if (fault) error <= 1'b1;
        end
    end

    // Storage without reset: register file and stack contents are defined by software.
    always_ff @(posedge Clock) begin
        if (advance) begin
            ir_instr <= iInstruction;
            ir_addr  <= ip;
            if (wr_en) regs[dst] <= wr_data;
            if (push) stack[sp] <= ir_addr + 1'b1;
        end
    end

    assign oIP     = ip;
    assign oLed    = led;
    assign oFlags  = flags;
    assign oHalted = halted;
    assign oError  = error;

endmodule

// File: tb/tb_mini_alu_gen.sv
// Directed bench for mini_alu_gen: table of ALU programs plus hand-traced
// sequences for branching, calls, stack faults, run-stall and mid-run reset.
module tb_mini_alu_gen;
    localparam int IPW = 16;
    localparam int LW  = 8;
    localparam int IW  = 28;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_MUL  = 4'd3;
    localparam logic [3:0] OP_STO  = 4'd4;
    localparam logic [3:0] OP_BLE  = 4'd5;
    localparam logic [3:0] OP_JMP  = 4'd6;
    localparam logic [3:0] OP_LED  = 4'd7;
    localparam logic [3:0] OP_CALL = 4'd8;
    localparam logic [3:0] OP_RET  = 4'd9;
    localparam logic [3:0] OP_HALT = 4'd10;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        int          led;
        int          flags;
    } alu_vec_t;

    logic           Clock = 1'b0;
    logic           Reset_n;
    logic           iRun;
    logic [IPW-1:0] oIP;
    logic [IW-1:0]  iInstruction;
    logic [LW-1:0]  oLed;
    logic [1:0]     oFlags;
    logic           oHalted;
    logic           oError;
    logic [IW-1:0]  rom [256];

    int checkCount = 0;
    int failCount  = 0;

    mini_alu_gen dut (
        .Clock        (Clock),
        .Reset_n      (Reset_n),
        .iRun         (iRun),
        .oIP          (oIP),
        .iInstruction (iInstruction),
        .oLed         (oLed),
        .oFlags       (oFlags),
        .oHalted      (oHalted),
        .oError       (oError)
    );

    always #5 Clock = ~Clock;

    assign iInstruction = (oIP < IPW'(256)) ? rom[oIP[7:0]] : '0;

    function automatic logic [IW-1:0] enc(input logic [3:0] op, input logic [7:0] d,
                                          input logic [7:0] s1, input logic [7:0] s0);
        return {op, d, s1, s0};
    endfunction

    function automatic logic [IW-1:0] sto(input logic [7:0] d, input logic [15:0] imm);
        return {OP_STO, d, imm[15:8], imm[7:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic clearRom();
        for (int i = 0; i < 256; i++) rom[i] = '0;
    endtask

    task automatic resetDut();
        Reset_n = 1'b0;
        iRun    = 1'b1;
        @(posedge Clock);
        #3;
        Reset_n = 1'b1;
    endtask

    task automatic runToHalt(input int maxEdges, output int edges);
        edges = 0;
        while (!oHalted && edges < maxEdges) begin
            step();
            edges++;
        end
    endtask

    task automatic applyStimulus(input alu_vec_t v);
        clearRom();
        rom[0] = sto(8'd1, v.a);
        rom[1] = sto(8'd2, v.b);
        rom[2] = sto(8'd3, 16'h0055);
        rom[3] = enc(v.op, 8'd3, 8'd1, 8'd2);
        rom[4] = enc(OP_LED, 8'd0, 8'd3, 8'd0);
        rom[5] = enc(OP_HALT, 8'd0, 8'd0, 8'd0);
        resetDut();
    endtask

    // Countdown: R1=5, R2=1; LED R1; R1-=R2; loop to 2 while R2 <= R1.
    task automatic loadCountdown();
        clearRom();
        rom[0] = sto(8'd1, 16'd5);
        rom[1] = sto(8'd2, 16'd1);
        rom[2] = enc(OP_LED, 8'd0, 8'd1, 8'd0);
        rom[3] = enc(OP_SUB, 8'd1, 8'd1, 8'd2);
        rom[4] = enc(OP_BLE, 8'd2, 8'd2, 8'd1);
        rom[5] = enc(OP_HALT, 8'd0, 8'd0, 8'd0);
    endtask

    alu_vec_t vecs[11];

    initial begin
        int edges;
        int nChanges;
        int ledSeen [8];
        int ledEdge [8];
        logic [LW-1:0]  prevLed;
        logic [IPW-1:0] heldIp;
        logic [LW-1:0]  heldLed;
        logic [1:0]     heldFlags;

        Reset_n = 1'b0;
        iRun    = 1'b1;
        clearRom();

        vecs[0]  = '{OP_ADD, 16'd3,    16'd5,    32'h08, 32'b00};
        vecs[1]  = '{OP_ADD, 16'hFFFF, 16'd1,    32'h00, 32'b11};
        vecs[2]  = '{OP_SUB, 16'd1,    16'hFFFF, 32'h02, 32'b10};
        vecs[3]  = '{OP_SUB, 16'd7,    16'd7,    32'h00, 32'b01};
        vecs[4]  = '{OP_SUB, 16'd10,   16'd3,    32'h07, 32'b00};
        vecs[5]  = '{OP_SUB, 16'd3,    16'd10,   32'hF9, 32'b10};
        vecs[6]  = '{OP_MUL, 16'h0100, 16'h0100, 32'h00, 32'b01};
        vecs[7]  = '{OP_MUL, 16'd12,   16'd11,   32'h84, 32'b00};
        vecs[8]  = '{OP_MUL, 16'hFFFF, 16'hFFFF, 32'h01, 32'b00};
        vecs[9]  = '{OP_ADD, 16'h80F0, 16'h8020, 32'h10, 32'b10};
        vecs[10] = '{4'd12,  16'd9,    16'd9,    32'h55, 32'b00};

        resetDut();
        checkOutput("reset ip", 32'(oIP), 0);
        checkOutput("reset led", 32'(oLed), 0);
        checkOutput("reset flags", 32'(oFlags), 0);
        checkOutput("reset halted", 32'(oHalted), 0);
        checkOutput("reset error", 32'(oError), 0);

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i]);
            runToHalt(40, edges);
            checkOutput($sformatf("vec%0d halt edge", i), edges, 7);
            checkOutput($sformatf("vec%0d led", i), 32'(oLed), vecs[i].led);
            checkOutput($sformatf("vec%0d flags", i), 32'(oFlags), vecs[i].flags);
        end

        // LED result appears two edges after the LED instruction is on oIP.
        clearRom();
        rom[0] = sto(8'd1, 16'd3);
        rom[1] = sto(8'd2, 16'd5);
        rom[2] = enc(OP_ADD, 8'd3, 8'd2, 8'd1);
        rom[3] = enc(OP_LED, 8'd0, 8'd3, 8'd0);
        rom[4] = enc(OP_HALT, 8'd0, 8'd0, 8'd0);
        resetDut();
        repeat (3) step();
        checkOutput("led fetch ip", 32'(oIP), 3);
        step();
        checkOutput("led latency edge1", 32'(oLed), 0);
        step();
        checkOutput("led latency edge2", 32'(oLed), 8);
        checkOutput("led latency flags", 32'(oFlags), 0);
        step();
        checkOutput("led halt", 32'(oHalted), 1);

        // Countdown loop: one bubble per taken branch puts LED updates 4 edges apart.
        loadCountdown();
        resetDut();
        for (int i = 0; i < 8; i++) begin ledSeen[i] = 0; ledEdge[i] = 0; end
        nChanges = 0; prevLed = oLed; edges = 0;
        while (!oHalted && edges < 60) begin
            step();
            edges++;
            if (oLed != prevLed) begin
                if (nChanges < 8) begin ledSeen[nChanges] = 32'(oLed); ledEdge[nChanges] = edges; end
                nChanges++;
                prevLed = oLed;
            end
        end
        checkOutput("loop led changes", nChanges, 5);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("loop led[%0d]", i), ledSeen[i], 5 - i);
            checkOutput($sformatf("loop led edge[%0d]", i), ledEdge[i], 4 + 4 * i);
        end
        checkOutput("loop halt edge", edges, 23);
        checkOutput("loop flags", 32'(oFlags), 32'b01);

        // Same loop stalled by iRun for 3 edges: same result, 3 edges later.
        loadCountdown();
        resetDut();
        nChanges = 0; prevLed = oLed; edges = 0;
        while (!oHalted && edges < 60) begin
            if (edges == 10) begin
                iRun = 1'b0;
                heldIp = oIP; heldLed = oLed; heldFlags = oFlags;
                for (int k = 0; k < 3; k++) begin
                    step();
                    edges++;
                    checkOutput($sformatf("stall ip %0d", k), 32'(oIP), 32'(heldIp));
                    checkOutput($sformatf("stall led %0d", k), 32'(oLed), 32'(heldLed));
                end
                checkOutput("stall flags", 32'(oFlags), 32'(heldFlags));
                iRun = 1'b1;
            end
            step();
            edges++;
            if (oLed != prevLed) begin nChanges++; prevLed = oLed; end
        end
        checkOutput("stall led changes", nChanges, 5);
        checkOutput("stall final led", 32'(oLed), 1);
        checkOutput("stall halt edge", edges, 26);

        // Unsigned BLE not taken; JMP squashes the STO behind it.
        clearRom();
        rom[0] = sto(8'd1, 16'hFFFF);
        rom[1] = sto(8'd2, 16'd1);
        rom[2] = enc(OP_BLE, 8'd5, 8'd1, 8'd2);
        rom[3] = sto(8'd3, 16'h000A);
        rom[4] = enc(OP_JMP, 8'd6, 8'd0, 8'd0);
        rom[5] = sto(8'd3, 16'h000B);
        rom[6] = enc(OP_LED, 8'd0, 8'd3, 8'd0);
        rom[7] = enc(OP_HALT, 8'd0, 8'd0, 8'd0);
        resetDut();
        runToHalt(40, edges);
        checkOutput("ble unsigned led", 32'(oLed), 32'h0A);
        checkOutput("ble unsigned halt", 32'(oHalted), 1);

        // CALL then RET returns to the instruction after the CALL.
        clearRom();
        rom[0] = sto(8'd1, 16'h0021);
        rom[1] = enc(OP_CALL, 8'd4, 8'd0, 8'd0);
        rom[2] = enc(OP_LED, 8'd0, 8'd1, 8'd0);
        rom[3] = enc(OP_HALT, 8'd0, 8'd0, 8'd0);
        rom[4] = enc(OP_LED, 8'd0, 8'd1, 8'd0);
        rom[5] = sto(8'd1, 16'h0033);
        rom[6] = enc(OP_RET, 8'd0, 8'd0, 8'd0);
        rom[7] = enc(OP_HALT, 8'd0, 8'd0, 8'd0);
        resetDut();
        runToHalt(40, edges);
        checkOutput("call ret halt edge", edges, 10);
        checkOutput("call ret led", 32'(oLed), 32'h33);
        checkOutput("call ret error", 32'(oError), 0);

        // Fifth nested CALL overflows a 4-deep stack.
        clearRom();
        rom[0] = sto(8'd1, 16'h0077);
        for (int i = 1; i <= 5; i++) rom[i] = enc(OP_CALL, 8'(i + 1), 8'd0, 8'd0);
        rom[6] = enc(OP_LED, 8'd0, 8'd1, 8'd0);
        resetDut();
        runToHalt(40, edges);
        checkOutput("overflow fault edge", edges, 11);
        checkOutput("overflow error", 32'(oError), 1);
        checkOutput("overflow halted", 32'(oHalted), 1);
        checkOutput("overflow ip", 32'(oIP), 7);
        repeat (4) step();
        checkOutput("overflow ip frozen", 32'(oIP), 7);
        checkOutput("overflow led", 32'(oLed), 0);
        checkOutput("overflow error sticky", 32'(oError), 1);

        // RET with an empty stack.
        clearRom();
        rom[0] = enc(OP_RET, 8'd0, 8'd0, 8'd0);
        rom[1] = enc(OP_LED, 8'd0, 8'd1, 8'd0);
        resetDut();
        runToHalt(20, edges);
        checkOutput("underflow fault edge", edges, 2);
        checkOutput("underflow error", 32'(oError), 1);
        checkOutput("underflow ip", 32'(oIP), 2);
        repeat (3) step();
        checkOutput("underflow ip frozen", 32'(oIP), 2);
        checkOutput("underflow led", 32'(oLed), 0);

        // Asynchronous reset between edges mid-loop, then a clean restart.
        loadCountdown();
        resetDut();
        repeat (10) step();
        checkOutput("pre-reset led", 32'(oLed), 4);
        #2;
        Reset_n = 1'b0;
        #1;
        checkOutput("async reset ip", 32'(oIP), 0);
        checkOutput("async reset led", 32'(oLed), 0);
        checkOutput("async reset flags", 32'(oFlags), 0);
        checkOutput("async reset halted", 32'(oHalted), 0);
        checkOutput("async reset error", 32'(oError), 0);
        @(posedge Clock);
        #1;
        checkOutput("reset held ip", 32'(oIP), 0);
        #2;
        Reset_n = 1'b1;
        runToHalt(60, edges);
        checkOutput("restart halt edge", edges, 23);
        checkOutput("restart led", 32'(oLed), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
